// File: rtl/gol_pkg.sv
// rtl/gol_pkg.sv - shared types for the Game of Life window scanner
package gol_pkg;

   typedef logic [8:0] status_t;

   localparam int NB_SELF = 0;
   localparam int NB_NW   = 1;
   localparam int NB_N    = 2;
   localparam int NB_NE   = 3;
   localparam int NB_W    = 4;
   localparam int NB_E    = 5;
   localparam int NB_SW   = 6;
   localparam int NB_S    = 7;
   localparam int NB_SE   = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SCAN,
      ST_ADV,
      ST_CAPT,
      ST_DONE
   } scan_state_t;

endpackage

// File: rtl/gol_row_window.sv
// rtl/gol_row_window.sv - 3x3 neighbourhood extraction from three row registers
module gol_row_window
   import gol_pkg::*;
#(
   parameter int WIDTH = 100,
   parameter bit WRAP  = 1'b0,
   parameter int X_W   = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] above,
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] below,
   input  logic [X_W-1:0]   x,
   output status_t          status
);

   logic           has_l;
   logic           has_r;
   logic [X_W-1:0] xl;
   logic [X_W-1:0] xr;

   // Off-board rows arrive as all-zero rows; only the column edges are decided here.
   always_comb begin
      has_l  = WRAP || (x != '0);
      has_r  = WRAP || (x != X_W'(WIDTH-1));
      xl     = (x == '0) ? X_W'(WIDTH-1) : x - X_W'(1);
      xr     = (x == X_W'(WIDTH-1)) ? '0 : x + X_W'(1);
      status = '0;
      status[NB_SELF] = cur[x];
      status[NB_NW]   = has_l & above[xl];
      status[NB_N]    = above[x];
      status[NB_NE]   = has_r & above[xr];
      status[NB_W]    = has_l & cur[xl];
      status[NB_E]    = has_r & cur[xr];
      status[NB_SW]   = has_l & below[xl];
      status[NB_S]    = below[x];
      status[NB_SE]   = has_r & below[xr];
   end

endmodule

// File: rtl/gol_window_scanner.sv
// rtl/gol_window_scanner.sv - row-major board scan emitting per-cell neighbourhood windows
module gol_window_scanner
   import gol_pkg::*;
#(
   parameter int WIDTH  = 100,
   parameter int HEIGHT = 100,
   parameter bit WRAP   = 1'b0,
   parameter int X_W    = $clog2(WIDTH),
   parameter int Y_W    = $clog2(HEIGHT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             rd_en,
   output logic [Y_W-1:0]   rd_addr,
   input  logic [WIDTH-1:0] rd_data,
   output logic             win_valid,
   input  logic             win_ready,
   output status_t          win_status,
   output logic [X_W-1:0]   win_x,
   output logic [Y_W-1:0]   win_y,
   output logic             win_last
);

   localparam int YP_W = Y_W + 1;
   // Number of preload reads; the LOAD step counter also exits on this value.
   localparam logic [1:0] LOAD_N = WRAP ? 2'd3 : 2'd2;

   scan_state_t      state, state_nx;
   logic [WIDTH-1:0] row_a, row_c, row_b;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [1:0]       cnt;
   logic             rd_pend;
   status_t          status;
   logic [YP_W-1:0]  y_plus2;
   logic [Y_W-1:0]   adv_addr;
   logic             adv_rd;
   logic             last_col, last_row;

   gol_row_window #(.WIDTH(WIDTH), .WRAP(WRAP), .X_W(X_W)) u_window (
      .above  (row_a),
      .cur    (row_c),
      .below  (row_b),
      .x      (x),
      .status (status)
   );

   assign last_col = (x == X_W'(WIDTH-1));
   assign last_row = (y == Y_W'(HEIGHT-1));

   always_comb begin
      y_plus2  = {1'b0, y} + YP_W'(2);
      adv_rd   = WRAP || (y_plus2 < YP_W'(HEIGHT));
      adv_addr = (y_plus2 >= YP_W'(HEIGHT)) ? Y_W'(y_plus2 - YP_W'(HEIGHT)) : Y_W'(y_plus2);
   end

   always_comb begin
      state_nx  = state;
      busy      = 1'b0;
      done      = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      win_valid = 1'b0;
      win_last  = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nx = ST_LOAD;
         ST_LOAD: begin
            busy = 1'b1;
            if (cnt < LOAD_N) begin
               rd_en = 1'b1;
               if (WRAP) rd_addr = (cnt == 2'd0) ? Y_W'(HEIGHT-1) : Y_W'(cnt - 2'd1);
               else      rd_addr = Y_W'(cnt);
            end
            if (cnt == LOAD_N) state_nx = ST_SCAN;
         end
         ST_SCAN: begin
            busy      = 1'b1;
            win_valid = 1'b1;
            win_last  = last_col && last_row;
            if (win_ready && last_col) state_nx = last_row ? ST_DONE : ST_ADV;
         end
         ST_ADV: begin
            busy     = 1'b1;
            rd_en    = adv_rd;
            rd_addr  = adv_rd ? adv_addr : '0;
            state_nx = ST_CAPT;
         end
         ST_CAPT: begin
            busy     = 1'b1;
            state_nx = ST_SCAN;
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign win_status = win_valid ? status : '0;
   assign win_x      = x;
   assign win_y      = y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         row_a   <= '0;
         row_c   <= '0;
         row_b   <= '0;
         x       <= '0;
         y       <= '0;
         cnt     <= '0;
         rd_pend <= 1'b0;
      end else begin
         state   <= state_nx;
         rd_pend <= rd_en;
         case (state)
            ST_IDLE: if (start) begin
               row_a <= '0;
               row_c <= '0;
               row_b <= '0;
               x     <= '0;
               y     <= '0;
               cnt   <= '0;
            end
            // Each returning read shifts the row stack up by one.
            ST_LOAD: begin
               cnt <= cnt + 2'd1;
               if (rd_pend) begin
                  row_a <= row_c;
                  row_c <= row_b;
                  row_b <= rd_data;
               end
            end
            ST_SCAN: if (win_ready) x <= last_col ? '0 : x + X_W'(1);
            ST_ADV: begin
               row_a <= row_c;
               row_c <= row_b;
            end
            ST_CAPT: begin
               row_b <= rd_pend ? rd_data : '0;
               y     <= y + Y_W'(1);
            end
            ST_DONE: begin
               x <= '0;
               y <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gol_window_scanner.sv
// tb/tb_gol_window_scanner.sv - scoreboard bench for 4x4 boards, WRAP=0 (dut 0) and WRAP=1 (dut 1)
module tb_gol_window_scanner;

   typedef struct packed {
      logic [8:0] st;
      logic [1:0] x;
      logic [1:0] y;
      logic       last;
   } win_t;

   logic       clk;
   logic       rst_n;
   logic       start_s      [2];
   logic       busy_s       [2];
   logic       done_s       [2];
   logic       rd_en_s      [2];
   logic [1:0] rd_addr_s    [2];
   logic [3:0] rd_data_s    [2];
   logic       win_valid_s  [2];
   logic       win_ready_s  [2];
   logic [8:0] win_status_s [2];
   logic [1:0] win_x_s      [2];
   logic [1:0] win_y_s      [2];
   logic       win_last_s   [2];

   logic [3:0] mem [2][4];
   logic [8:0] got [2][4][4];
   logic [8:0] first_got [4][4];
   win_t       sbq [$];
   int         checks = 0;
   int         errors = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      gol_window_scanner #(.WIDTH(4), .HEIGHT(4), .WRAP(g == 1)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start_s[g]),
         .busy       (busy_s[g]),
         .done       (done_s[g]),
         .rd_en      (rd_en_s[g]),
         .rd_addr    (rd_addr_s[g]),
         .rd_data    (rd_data_s[g]),
         .win_valid  (win_valid_s[g]),
         .win_ready  (win_ready_s[g]),
         .win_status (win_status_s[g]),
         .win_x      (win_x_s[g]),
         .win_y      (win_y_s[g]),
         .win_last   (win_last_s[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      for (int i = 0; i < 2; i++)
         if (rd_en_s[i]) rd_data_s[i] <= mem[i][rd_addr_s[i]];

   function automatic logic [8:0] gold(input int d, input int x, input int y);
      int dxs [9];
      int dys [9];
      int nx, ny;
      logic [8:0] r;
      logic [3:0] row;
      dxs = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
      dys = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
      r = '0;
      for (int i = 0; i < 9; i++) begin
         nx = x + dxs[i];
         ny = y + dys[i];
         if (d == 1) begin
            nx = (nx + 4) % 4;
            ny = (ny + 4) % 4;
         end
         if (nx >= 0 && nx < 4 && ny >= 0 && ny < 4) begin
            row  = mem[d][ny];
            r[i] = row[nx];
         end
      end
      return r;
   endfunction

   task automatic push_expected(input int d);
      win_t e;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++) begin
            e.st   = gold(d, x, y);
            e.x    = 2'(x);
            e.y    = 2'(y);
            e.last = (x == 3 && y == 3);
            sbq.push_back(e);
         end
   endtask

   task automatic run_scan(input int d, input bit stall, input bit pulse, input int abort_at);
      int   n, gap, stall_left, exp_gap;
      bit   want_done, fin;
      win_t e;
      sbq.delete();
      push_expected(d);
      n = 0; gap = 0; want_done = 0; fin = 0;
      stall_left = stall ? 5 : 0;
      win_ready_s[d] = 1'b1;
      @(negedge clk); start_s[d] = 1'b1;
      @(negedge clk); start_s[d] = 1'b0;
      checks++;
      if (rd_en_s[d] !== 1'b1 || rd_addr_s[d] !== 2'(d == 1 ? 3 : 0) || busy_s[d] !== 1'b1) begin
         errors++;
         $display("FAIL first_read d%0d: rd_en=%b rd_addr=%0d busy=%b, want 1 %0d 1",
                  d, rd_en_s[d], rd_addr_s[d], busy_s[d], (d == 1 ? 3 : 0));
      end
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         if (cyc > 0) @(negedge clk);
         start_s[d] = pulse && (cyc == 20);
         if (abort_at >= 0 && n == abort_at && win_valid_s[d]) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if ({win_valid_s[d], busy_s[d], rd_en_s[d]} !== 3'b000) begin
               errors++;
               $display("FAIL abort_outputs d%0d: valid/busy/rd_en=%b, want 000",
                        d, {win_valid_s[d], busy_s[d], rd_en_s[d]});
            end
            @(negedge clk);
            rst_n = 1'b1;
            start_s[d] = 1'b0;
            sbq.delete();
            return;
         end
         if (want_done) begin
            checks++;
            if (done_s[d] !== 1'b1 || busy_s[d] !== 1'b0) begin
               errors++;
               $display("FAIL done_pulse d%0d: done=%b busy=%b, want 1 0", d, done_s[d], busy_s[d]);
            end
            start_s[d] = pulse;
            @(negedge clk);
            start_s[d] = 1'b0;
            checks++;
            if (done_s[d] !== 1'b0 || busy_s[d] !== 1'b0 || rd_en_s[d] !== 1'b0) begin
               errors++;
               $display("FAIL after_done d%0d: done=%b busy=%b rd_en=%b, want 0 0 0",
                        d, done_s[d], busy_s[d], rd_en_s[d]);
            end
            fin = 1;
         end else if (win_valid_s[d]) begin
            if (stall_left > 0 && win_x_s[d] == 2'd2 && win_y_s[d] == 2'd1) begin
               win_ready_s[d] = 1'b0;
               stall_left--;
               checks++;
               if (sbq.size() == 0 || win_status_s[d] !== sbq[0].st ||
                   win_x_s[d] !== sbq[0].x || win_y_s[d] !== sbq[0].y) begin
                  errors++;
                  $display("FAIL stall_hold d%0d: got st=%h x=%0d y=%0d", d,
                           win_status_s[d], win_x_s[d], win_y_s[d]);
               end
            end else begin
               win_ready_s[d] = 1'b1;
               checks++;
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL extra_window d%0d: x=%0d y=%0d, want no window", d, win_x_s[d], win_y_s[d]);
                  fin = 1;
               end else begin
                  e = sbq.pop_front();
                  exp_gap = (n == 0) ? (d == 1 ? 4 : 3) : (e.x == 2'd0 ? 2 : 0);
                  if (gap !== exp_gap) begin
                     errors++;
                     $display("FAIL gap d%0d (%0d,%0d): %0d idle cycles, want %0d", d, e.x, e.y, gap, exp_gap);
                  end
                  checks++;
                  if ({win_status_s[d], win_x_s[d], win_y_s[d], win_last_s[d]} !== {e.st, e.x, e.y, e.last}) begin
                     errors++;
                     $display("FAIL window d%0d #%0d: st=%h x=%0d y=%0d last=%b, want st=%h x=%0d y=%0d last=%b",
                              d, n, win_status_s[d], win_x_s[d], win_y_s[d], win_last_s[d],
                              e.st, e.x, e.y, e.last);
                  end
                  got[d][e.y][e.x] = win_status_s[d];
                  n++;
                  gap = 0;
                  want_done = e.last;
               end
            end
         end else begin
            win_ready_s[d] = 1'b1;
            gap++;
            checks++;
            if (done_s[d] !== 1'b0) begin
               errors++;
               $display("FAIL early_done d%0d: done=1 after %0d windows, want 0", d, n);
            end
         end
      end
      checks++;
      if (!fin || n != 16 || sbq.size() != 0) begin
         errors++;
         $display("FAIL scan_count d%0d: windows=%0d finished=%0d left=%0d, want 16 1 0", d, n, fin, sbq.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({busy_s[d], done_s[d], rd_en_s[d], rd_addr_s[d], win_valid_s[d],
              win_status_s[d], win_x_s[d], win_y_s[d], win_last_s[d]} !== '0) begin
            errors++;
            $display("FAIL reset_outputs d%0d: busy=%b done=%b rd_en=%b valid=%b st=%h, want all 0",
                     d, busy_s[d], done_s[d], rd_en_s[d], win_valid_s[d], win_status_s[d]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_nowrap_scan();
      mem[0] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000};
      run_scan(0, 1'b0, 1'b0, -1);
      checks++;
      if ({got[0][1][1], got[0][0][0], got[0][2][2], got[0][3][3]} !== {9'h001, 9'h100, 9'h002, 9'h000}) begin
         errors++;
         $display("FAIL nowrap_cells: (1,1)=%h (0,0)=%h (2,2)=%h (3,3)=%h, want 001 100 002 000",
                  got[0][1][1], got[0][0][0], got[0][2][2], got[0][3][3]);
      end
   endtask

   task automatic test_wrap_scan();
      mem[1] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
      run_scan(1, 1'b0, 1'b0, -1);
      checks++;
      if ({got[1][3][3], got[1][1][1], got[1][0][3], got[1][3][0]} !== {9'h100, 9'h002, 9'h020, 9'h080}) begin
         errors++;
         $display("FAIL wrap_cells: (3,3)=%h (1,1)=%h (3,0)=%h (0,3)=%h, want 100 002 020 080",
                  got[1][3][3], got[1][1][1], got[1][0][3], got[1][3][0]);
      end
   endtask

   task automatic test_random_boards();
      for (int d = 0; d < 2; d++) begin
         for (int r = 0; r < 4; r++) mem[d][r] = 4'($urandom);
         run_scan(d, 1'b0, 1'b0, -1);
      end
   endtask

   task automatic test_backpressure();
      for (int r = 0; r < 4; r++) mem[0][r] = 4'($urandom);
      run_scan(0, 1'b1, 1'b0, -1);
   endtask

   task automatic test_latency();
      int exp_rd   [2][5];
      int exp_addr [2][5];
      int exp_v    [2][5];
      exp_rd   = '{'{1, 1, 0, 0, 1}, '{1, 1, 1, 0, 0}};
      exp_addr = '{'{0, 1, 0, 0, 0}, '{3, 0, 1, 0, 0}};
      exp_v    = '{'{0, 0, 0, 1, 1}, '{0, 0, 0, 0, 1}};
      for (int d = 0; d < 2; d++) begin
         win_ready_s[d] = 1'b0;
         @(negedge clk); start_s[d] = 1'b1;
         @(negedge clk); start_s[d] = 1'b0;
         for (int k = 0; k < (d == 1 ? 5 : 4); k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (rd_en_s[d] !== 1'(exp_rd[d][k]) || win_valid_s[d] !== 1'(exp_v[d][k]) ||
                (exp_rd[d][k] == 1 && rd_addr_s[d] !== 2'(exp_addr[d][k]))) begin
               errors++;
               $display("FAIL latency d%0d T+%0d: rd_en=%b rd_addr=%0d valid=%b, want %0d %0d %0d",
                        d, k + 1, rd_en_s[d], rd_addr_s[d], win_valid_s[d],
                        exp_rd[d][k], exp_addr[d][k], exp_v[d][k]);
            end
         end
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 4; r++) mem[0][r] = 4'($urandom);
      run_scan(0, 1'b0, 1'b1, -1);
      first_got = got[0];
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (busy_s[0] !== 1'b0 || rd_en_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start: busy=%b rd_en=%b, want 0 0", busy_s[0], rd_en_s[0]);
         end
      end
      run_scan(0, 1'b0, 1'b0, -1);
      checks++;
      if (got[0] != first_got) begin
         errors++;
         $display("FAIL rescan_identical: second scan differs from first, want identical");
      end
   endtask

   task automatic test_reset_midscan();
      for (int r = 0; r < 4; r++) mem[0][r] = 4'($urandom);
      run_scan(0, 1'b0, 1'b0, 6);
      run_scan(0, 1'b0, 1'b0, -1);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_s[d]     = 1'b0;
         win_ready_s[d] = 1'b0;
         for (int r = 0; r < 4; r++) mem[d][r] = '0;
      end
      test_reset();
      test_latency();
      test_nowrap_scan();
      test_wrap_scan();
      test_backpressure();
      test_random_boards();
      test_back_to_back();
      test_reset_midscan();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
